// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI receive endpoint.
//   SPI_DATA_W  : default word width
//   CPOL / CPHA : SPI mode handled by the receiver (mode 0)
//   spi_state_t : receiver FSM state encoding
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W = 16;

  // Mode 0: SCLK idles low, data sampled on the rising SCLK edge.
  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous SPI pin into the clk domain and derives edges.
// The pin passes through SYNC_STAGES flops; one further delay flop holds the
// previous synced level so rise/fall are single-cycle pulses.
//
// Parameters:
//   SYNC_STAGES : synchronizer depth (>= 2)
//   RESET_VAL   : value of every stage while reset is asserted
// Ports:
//   clk, reset : local clock, asynchronous active-high reset
//   din        : asynchronous pin
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synced level transitions
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_rx_slave.sv
// ---------------------------------------------------------------------------
// spi_rx_slave
// SPI mode-0 receive endpoint (MSB first). Oversamples cs/sclk/data on clk,
// shifts in DATA_W-bit words while CS is low (back-to-back words allowed)
// and presents each completed word in a valid/ready holding register.
//
// Handshake: dout is transferred when dout_valid & dout_ready are both high
// on a clk edge. dout_valid stays high until that transfer; a newly
// completed word loading on the same edge keeps dout_valid high. A word
// completing while dout_valid & !dout_ready is dropped and flagged by
// overrun.
//
// Parameters:
//   DATA_W      : word width (>= 2)
//   SYNC_STAGES : synchronizer depth per SPI input (>= 2)
// Ports:
//   clk, reset  : local clock, asynchronous active-high reset
//   spi_cs_l    : chip select, active low (asynchronous)
//   spi_sclk    : SPI clock (asynchronous)
//   spi_data    : serial data, MOSI (asynchronous)
//   dout        : last received word
//   dout_valid  : dout holds an unconsumed word
//   dout_ready  : consumer accepts dout
//   frame_err   : one-cycle pulse, CS rose mid-word (partial word dropped)
//   overrun     : one-cycle pulse, completed word dropped
//   busy        : receiver FSM is in SHIFT
//   bit_count   : (only with SPI_RX_BITCNT_EN) internal bit counter
//
// Build option: define SPI_RX_BITCNT_EN to expose the bit counter.
// SCLK high and low phases must each last >= SYNC_STAGES+1 clk cycles.
// ---------------------------------------------------------------------------
module spi_rx_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_l,
  input  logic              spi_sclk,
  input  logic              spi_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
`ifdef SPI_RX_BITCNT_EN
  ,
  output logic [$clog2(DATA_W):0] bit_count
`endif
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  // Synchronized pins and edges. Only the level of data is used; the other
  // unused outputs are collected into unused_edges.
  logic cs_rise, cs_fall, sclk_rise, data_level;
  logic unused_cs_level, unused_sclk_level, unused_sclk_fall;
  logic unused_data_rise, unused_data_fall;
  logic unused_edges;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .din   (spi_cs_l),
    .level (unused_cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (spi_sclk),
    .level (unused_sclk_level),
    .rise  (sclk_rise),
    .fall  (unused_sclk_fall)
  );

  // Same depth as the sclk path, so data_level is aligned with sclk_rise.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
    .clk   (clk),
    .reset (reset),
    .din   (spi_data),
    .level (data_level),
    .rise  (unused_data_rise),
    .fall  (unused_data_fall)
  );

  assign unused_edges = unused_cs_level ^ unused_sclk_level ^ unused_sclk_fall
                      ^ unused_data_rise ^ unused_data_fall;

  // FSM and datapath registers
  spi_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] dout_d;
  logic              dout_valid_d, frame_err_d, overrun_d;
  logic              word_done, load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      frame_err  <= frame_err_d;
      overrun    <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    word_done   = 1'b0;
    frame_err_d = 1'b0;
    word        = {shreg_q[DATA_W-2:0], data_level};

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // CS release wins over a coincident sclk rise.
        if (cs_rise) begin
          state_d     = IDLE;
          cnt_d       = '0;
          shreg_d     = '0;
          frame_err_d = (cnt_q != '0);
        end else if (sclk_rise) begin
          shreg_d = word;
          if (cnt_q == LAST_BIT) begin
            cnt_d     = '0;
            word_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Holding register: a load wins over a simultaneous consume.
    load         = word_done & (~dout_valid | dout_ready);
    overrun_d    = word_done & ~load;
    dout_d       = load ? word : dout;
    dout_valid_d = load | (dout_valid & ~dout_ready);
  end

  assign busy = (state_q == SHIFT);

`ifdef SPI_RX_BITCNT_EN
  assign bit_count = cnt_q;
`endif

endmodule

// File: tb/tb_spi_rx_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_slave
// Drives pin-level SPI frames into spi_rx_slave and checks every output on
// every cycle against a behavioural model. The model sees each pin through a
// plain history array delayed by the synchronizer depth and applies the
// frame/word/handshake rules with integer counters. Literal expectations
// (expected word queue, pulse counts, latency) pin the model.
// ---------------------------------------------------------------------------
module tb_spi_rx_slave;

  localparam int DW = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          spi_cs_l, spi_sclk, spi_data;
  logic [DW-1:0] dout;
  logic          dout_valid, dout_ready, frame_err, overrun, busy;
`ifdef SPI_RX_BITCNT_EN
  logic [$clog2(DW):0] bit_count;
`endif

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  spi_rx_slave #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_cs_l   (spi_cs_l),
    .spi_sclk   (spi_sclk),
    .spi_data   (spi_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
`ifdef SPI_RX_BITCNT_EN
    ,
    .bit_count  (bit_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            cyc = 0;
  bit            h_cs[64];
  bit            h_sck[64];
  bit            h_dat[64];
  bit            m_busy, m_valid, m_ferr, m_ovr;
  int            m_nbits;
  logic [DW-1:0] m_acc, m_dout;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) begin : model_p
    int n, i0, i1;
    bit cl, cp, sl, sp, dl, done;
    cyc++;
    n  = cyc % 64;
    i0 = (cyc - SS + 64) % 64;       // synced level seen at this edge
    i1 = (cyc - SS - 1 + 64) % 64;   // synced level one edge earlier
    if (reset) begin
      h_cs[n] = 1'b0; h_sck[n] = 1'b0; h_dat[n] = 1'b0;
      m_busy = 1'b0; m_nbits = 0; m_acc = '0; m_dout = '0;
      m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      h_cs[n] = spi_cs_l; h_sck[n] = spi_sclk; h_dat[n] = spi_data;
      cl = h_cs[i0];  cp = h_cs[i1];
      sl = h_sck[i0]; sp = h_sck[i1];
      dl = h_dat[i0];
      done   = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (!m_busy) begin
        if (!cl && cp) begin m_busy = 1'b1; m_nbits = 0; end
      end else if (cl && !cp) begin
        m_busy = 1'b0;
        if (m_nbits != 0) m_ferr = 1'b1;
        m_nbits = 0;
      end else if (sl && !sp) begin
        m_acc = {m_acc[DW-2:0], dl};
        m_nbits++;
        if (m_nbits == DW) begin done = 1'b1; m_nbits = 0; end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_extra: got %0h expected none", m_acc);
        end else begin
          chk("sb_word", m_acc, exp_q.pop_front());
        end
        if (!m_valid || dout_ready) begin
          m_dout  = m_acc;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && dout_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  int ferr_cnt = 0, ovr_cnt = 0, vrise_cnt = 0, vhi_cnt = 0, vrise_cyc = 0;
  bit prev_valid = 1'b0;

  always @(negedge clk) begin
    chk("dout", dout, m_dout);
    chk("dout_valid", dout_valid, m_valid);
    chk("frame_err", frame_err, m_ferr);
    chk("overrun", overrun, m_ovr);
    chk("busy", busy, m_busy);
`ifdef SPI_RX_BITCNT_EN
    chk("bit_count", bit_count, m_nbits);
`endif
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (dout_valid) vhi_cnt++;
    if (dout_valid && !prev_valid) begin
      vrise_cnt++;
      vrise_cyc = cyc;
    end
    prev_valid = dout_valid;
  end

  // ---------------- driver tasks ----------------
  bit rnd_en = 1'b0;
  int last_rise_cyc = 0;

  task automatic step();
    @(negedge clk);
    #1;
    if (rnd_en) dout_ready = ($urandom_range(0, 15) == 0);
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic send_bits(input logic [63:0] bits, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      spi_data = bits[nbits-1-i];
      wait_n(half);
      spi_sclk = 1'b1;
      last_rise_cyc = cyc + 1;       // first clk edge that samples this rise
      wait_n(half);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [63:0] bits, input int nbits, input int half);
    spi_cs_l = 1'b0;
    wait_n(half);
    send_bits(bits, nbits, half);
    wait_n(half);
    spi_cs_l = 1'b1;
    wait_n(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #5000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int f0, v0, r0, o0;
    logic [DW-1:0] w1, w2;
    int half, kind, nb;

    reset = 1'b1; spi_cs_l = 1'b1; spi_sclk = 1'b0; spi_data = 1'b0;
    dout_ready = 1'b0;
    wait_n(3);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    wait_n(4);

    // Single frame, sclk period 8, consumer always ready.
    dout_ready = 1'b1;
    f0 = ferr_cnt; v0 = vhi_cnt;
    exp_q.push_back(16'hA569);
    frame(64'hA569, 16, 4);
    chk("t1_dout", dout, 16'hA569);
    chk("t1_valid_cycles", vhi_cnt - v0, 1);
    // Valid observed after the third edge counting the sampling edge.
    chk("t1_latency", vrise_cyc - last_rise_cyc, SS);
    chk("t1_ferr", ferr_cnt - f0, 0);

    // Two frames with consumer stalled: second word dropped.
    dout_ready = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(16'h2563);
    exp_q.push_back(16'h9B63);
    frame(64'h2563, 16, 4);
    frame(64'h9B63, 16, 4);
    chk("t2_dout", dout, 16'h2563);
    chk("t2_valid", dout_valid, 1);
    chk("t2_overrun", ovr_cnt - o0, 1);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    chk("t2_consumed", dout_valid, 0);

    // Aborted frame after 7 bits, then a full frame.
    dout_ready = 1'b1;
    f0 = ferr_cnt; r0 = vrise_cnt;
    frame(64'h6A61 >> 9, 7, 4);
    chk("t3_ferr", ferr_cnt - f0, 1);
    chk("t3_no_word", vrise_cnt - r0, 0);
    exp_q.push_back(16'h6A61);
    frame(64'h6A61, 16, 4);
    chk("t3_dout", dout, 16'h6A61);

    // Two words under one CS-low.
    r0 = vrise_cnt;
    exp_q.push_back(16'hA265);
    exp_q.push_back(16'h7564);
    frame({32'h0, 16'hA265, 16'h7564}, 32, 4);
    chk("t4_words", vrise_cnt - r0, 2);
    chk("t4_dout", dout, 16'h7564);
    chk("t4_busy_after", busy, 0);

    // Reset mid-frame with CS held low.
    spi_cs_l = 1'b0;
    wait_n(4);
    send_bits(64'h75, 8, 4);
    reset = 1'b1;
    step();
    chk("t5_rst_dout", dout, 0);
    chk("t5_rst_valid", dout_valid, 0);
    chk("t5_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    r0 = vrise_cnt;
    send_bits(64'h64, 8, 4);
    wait_n(6);
    chk("t5_no_word", vrise_cnt - r0, 0);
    chk("t5_idle", busy, 0);
    spi_cs_l = 1'b1;
    wait_n(4);
    exp_q.push_back(16'hA569);
    frame(64'hA569, 16, 4);
    chk("t5_dout", dout, 16'hA569);

`ifdef SPI_RX_BITCNT_EN
    // Counter steps and wraps.
    exp_q.push_back(16'h1234);
    spi_cs_l = 1'b0;
    wait_n(4);
    send_bits(64'h1234 >> 11, 5, 4);
    wait_n(4);
    chk("t6_cnt5", bit_count, 5);
    send_bits(64'h1234 & 64'h7FF, 11, 4);
    wait_n(4);
    chk("t6_wrap", bit_count, 0);
    chk("t6_busy", busy, 1);
    spi_cs_l = 1'b1;
    wait_n(6);
    chk("t6_idle_cnt", bit_count, 0);
`endif

    // Randomized frames with a mostly-stalled consumer.
    rnd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      w1   = DW'($urandom);
      w2   = DW'($urandom);
      half = $urandom_range(3, 6);
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        nb = $urandom_range(1, DW - 1);
        frame({48'h0, w1}, nb, half);
      end else if (kind == 1) begin
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        frame({32'h0, w1, w2}, 32, half);
      end else begin
        exp_q.push_back(w1);
        frame({48'h0, w1}, 16, half);
      end
      wait_n($urandom_range(0, 8));
    end
    rnd_en = 1'b0;
    dout_ready = 1'b1;
    wait_n(10);
    chk("sb_leftover", exp_q.size(), 0);
    chk("final_valid", dout_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
